// File: rtl/pic_bus_if.sv
// Host-side 8259A bus bundle: PIC pins plus the CPU-side control and vector handshake.
interface pic_bus_if;
    logic       start;
    logic       busy;
    logic       init_done;
    logic       cs;
    logic       wr;
    logic       rd;
    logic       a0;
    logic [7:0] d_out;
    logic       d_oe;
    logic [7:0] d_in;
    logic       intr;
    logic       inta;
    logic       vec_valid;
    logic [7:0] vec;
    logic       vec_ready;

    modport master (
        input  start, d_in, intr, vec_ready,
        output busy, init_done, cs, wr, rd, a0, d_out, d_oe, inta, vec_valid, vec
    );

    modport slave (
        output start, d_in, intr, vec_ready,
        input  busy, init_done, cs, wr, rd, a0, d_out, d_oe, inta, vec_valid, vec
    );
endinterface

// File: rtl/pic_bus_sequencer.sv
// Drives the 8259A bus: ICW1/ICW2/ICW4/OCW1 init, two-pulse INTA acknowledge,
// vector hand-off to the CPU and a non-specific EOI after each accepted vector.
module pic_bus_sequencer #(
    parameter logic [7:0]  ICW1_VAL  = 8'h13,
    parameter logic [7:0]  ICW2_VAL  = 8'hA8,
    parameter logic [7:0]  ICW4_VAL  = 8'h01,
    parameter logic [7:0]  OCW1_VAL  = 8'h00,
    parameter logic [7:0]  EOI_VAL   = 8'h20,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned GAP_CYC   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    pic_bus_if.master     bus
);
    localparam int unsigned CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_W_SETUP, S_W_STROBE, S_W_GAP, S_READY,
        S_ACK1_LO, S_ACK1_HI, S_ACK2_LO, S_VEC_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic             is_eoi;
    logic [1:0]       int_sync;
    logic             int_s;

    assign int_s  = int_sync[1];
    assign bus.rd = 1'b1;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        case (i)
            2'd0:    return ICW1_VAL;
            2'd1:    return ICW2_VAL;
            2'd2:    return ICW4_VAL;
            default: return OCW1_VAL;
        endcase
    endfunction

    // Two-flop synchroniser for the asynchronous PIC INT line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) int_sync <= 2'b00;
        else        int_sync <= {int_sync[0], bus.intr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            idx           <= 2'd0;
            is_eoi        <= 1'b0;
            bus.busy      <= 1'b0;
            bus.init_done <= 1'b0;
            bus.cs        <= 1'b1;
            bus.wr        <= 1'b1;
            bus.a0        <= 1'b0;
            bus.d_out     <= 8'h00;
            bus.d_oe      <= 1'b0;
            bus.inta      <= 1'b1;
            bus.vec_valid <= 1'b0;
            bus.vec       <= 8'h00;
        end else begin
            case (state)
                S_IDLE, S_READY: begin
                    // START outranks a pending interrupt; interrupts only count once initialised
                    if (bus.start) begin
                        state         <= S_W_SETUP;
                        idx           <= 2'd0;
                        is_eoi        <= 1'b0;
                        bus.init_done <= 1'b0;
                        bus.busy      <= 1'b1;
                        bus.cs        <= 1'b0;
                        bus.wr        <= 1'b1;
                        bus.a0        <= 1'b0;
                        bus.d_out     <= init_byte(2'd0);
                        bus.d_oe      <= 1'b1;
                    end else if (state == S_READY && int_s) begin
                        state    <= S_ACK1_LO;
                        cnt      <= PULSE_LD;
                        bus.busy <= 1'b1;
                        bus.inta <= 1'b0;
                    end
                end
                S_W_SETUP: begin
                    state  <= S_W_STROBE;
                    cnt    <= PULSE_LD;
                    bus.wr <= 1'b0;
                end
                S_W_STROBE: begin
                    if (cnt == '0) begin
                        state  <= S_W_GAP;
                        cnt    <= GAP_LD;
                        bus.wr <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_W_GAP: begin
                    // Address and data are held through the gap, then the next write or release
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!is_eoi && idx != 2'd3) begin
                        state     <= S_W_SETUP;
                        idx       <= idx + 2'd1;
                        bus.a0    <= 1'b1;
                        bus.d_out <= init_byte(idx + 2'd1);
                    end else begin
                        state    <= S_READY;
                        bus.busy <= 1'b0;
                        bus.cs   <= 1'b1;
                        bus.d_oe <= 1'b0;
                        if (!is_eoi) bus.init_done <= 1'b1;
                    end
                end
                S_ACK1_LO: begin
                    if (cnt == '0) begin
                        state    <= S_ACK1_HI;
                        cnt      <= GAP_LD;
                        bus.inta <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_ACK1_HI: begin
                    if (cnt == '0) begin
                        state    <= S_ACK2_LO;
                        cnt      <= PULSE_LD;
                        bus.inta <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_ACK2_LO: begin
                    if (cnt == '0) begin
                        state         <= S_VEC_WAIT;
                        bus.inta      <= 1'b1;
                        bus.vec       <= bus.d_in;
                        bus.vec_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_VEC_WAIT: begin
                    if (bus.vec_valid && bus.vec_ready) begin
                        state         <= S_W_SETUP;
                        is_eoi        <= 1'b1;
                        bus.vec_valid <= 1'b0;
                        bus.cs        <= 1'b0;
                        bus.wr        <= 1'b1;
                        bus.a0        <= 1'b0;
                        bus.d_out     <= EOI_VAL;
                        bus.d_oe      <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pic_bus_sequencer.sv
// Randomised scoreboard bench for pic_bus_sequencer with a behavioural 8259A responder.
module tb_pic_bus_sequencer;
    localparam int unsigned PULSE = 4;
    localparam int unsigned GAP   = 4;

    logic clk = 1'b0;
    logic rst_n;
    pic_bus_if bus();

    pic_bus_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [8:0] wq[$];
    logic [7:0] vq[$];
    int inta_falls = 0;
    int delivered  = 0;
    bit rdy_auto = 1'b0;
    bit rdy_val  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.init_done;
            1:       return bus.inta;
            2:       return bus.busy;
            default: return bus.vec_valid;
        endcase
    endfunction

    task automatic wait_sig(input string name, input int which, input logic val,
                            input int max_cyc, output int n);
        n = 0;
        while (sig(which) !== val && n < max_cyc) begin
            @(posedge clk); #1; n++;
        end
        if (sig(which) !== val) fail_now({name, "_timeout"});
    endtask

    // CPU-side acceptor: random ready or a forced level
    always @(posedge clk) begin
        #2;
        bus.vec_ready = rdy_auto ? ($urandom_range(0, 2) == 0) : rdy_val;
    end

    // 8259A responder: normal vector if INT is still up at the first INTA, else spurious IR7
    bit pic_par = 1'b0;
    bit pic_norm = 1'b0;
    always @(negedge bus.inta or negedge rst_n) begin
        if (!rst_n) begin
            pic_par = 1'b0;
        end else if (!pic_par) begin
            pic_norm = bus.intr;
            pic_par  = 1'b1;
        end else begin
            bus.d_in = pic_norm ? 8'(8'hA8 + $urandom_range(0, 6)) : 8'hAF;
            vq.push_back(bus.d_in);
            pic_par = 1'b0;
        end
    end

    // Monitor: pops expected writes and vectors, checks strobe widths and hold
    bit prev_wr = 1'b1, prev_inta = 1'b1, prev_vv = 1'b0, prev_hs = 1'b0, mon_par = 1'b0;
    logic [7:0] prev_vec;
    logic [8:0] wr_held;
    int wr_len = 0, inta_len = 0, inta_hi = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            wq.delete(); vq.delete();
            prev_wr = 1'b1; prev_inta = 1'b1; prev_vv = 1'b0; prev_hs = 1'b0; mon_par = 1'b0;
            wr_len = 0; inta_len = 0; inta_hi = 0;
        end else begin
            check("rd_high", bus.rd, 1);
            if (prev_wr && !bus.wr) begin
                if (wq.size() == 0) fail_now("wr_unexpected");
                else check("wr_data", {bus.a0, bus.d_out}, wq.pop_front());
                check("wr_cs", bus.cs, 0);
                check("wr_oe", bus.d_oe, 1);
                wr_held = {bus.a0, bus.d_out};
                wr_len  = 1;
            end else if (!bus.wr) wr_len++;
            if (!prev_wr && bus.wr) begin
                check("wr_pulse", wr_len, PULSE);
                check("wr_hold", {bus.a0, bus.d_out}, wr_held);
            end
            if (!bus.inta) check("inta_cs", bus.cs, 1);
            if (prev_inta && !bus.inta) begin
                if (mon_par) check("inta_gap", inta_hi, GAP);
                mon_par = !mon_par;
                inta_len = 1;
                inta_falls++;
            end else if (!bus.inta) inta_len++;
            if (!prev_inta && bus.inta) begin
                check("inta_pulse", inta_len, PULSE);
                inta_hi = 1;
            end else if (bus.inta) inta_hi++;
            if (prev_hs) check("vv_drop", bus.vec_valid, 0);
            else if (prev_vv) begin
                check("vv_hold", bus.vec_valid, 1);
                check("vec_hold", bus.vec, prev_vec);
            end
            prev_hs = bus.vec_valid && bus.vec_ready;
            if (prev_hs) begin
                if (vq.size() == 0) fail_now("vec_unexpected");
                else check("vec", bus.vec, vq.pop_front());
                delivered++;
                wq.push_back(9'h020);
            end
            prev_wr = bus.wr; prev_inta = bus.inta; prev_vv = bus.vec_valid; prev_vec = bus.vec;
        end
    end

    task automatic push_init();
        wq.push_back(9'h013); wq.push_back(9'h1A8); wq.push_back(9'h101); wq.push_back(9'h100);
    endtask

    task automatic do_init();
        int n;
        @(posedge clk); #1 bus.start = 1'b1;
        push_init();
        @(posedge clk); #1 bus.start = 1'b0;
        check("init_clr", bus.init_done, 0);
        n = 0;
        while (!bus.init_done && n < 200) begin
            check("busy_init", bus.busy, 1);
            @(posedge clk); #1; n++;
        end
        if (!bus.init_done) fail_now("init_timeout");
        check("init_len", n, 36);
        check("busy_ready", bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, f0, d0, pulses;
        rst_n = 1'b0; bus.start = 1'b0; bus.intr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", bus.cs, 1);       check("rst_wr", bus.wr, 1);
        check("rst_rd", bus.rd, 1);       check("rst_inta", bus.inta, 1);
        check("rst_a0", bus.a0, 0);       check("rst_dout", bus.d_out, 0);
        check("rst_oe", bus.d_oe, 0);     check("rst_vv", bus.vec_valid, 0);
        check("rst_vec", bus.vec, 0);     check("rst_done", bus.init_done, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;

        // INT before initialisation must be ignored
        @(posedge clk); #1 bus.intr = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus.intr = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("idle_no_inta", inta_falls, 0);
        check("idle_busy", bus.busy, 0);

        do_init();

        // First interrupt: latency, held vector, EOI, back-to-back ACK1
        @(posedge clk); #1 bus.intr = 1'b1;
        wait_sig("ack_lat", 1, 1'b0, 20, n);
        check("int_to_inta", n, 3);
        wait_sig("vv_up", 3, 1'b1, 100, n);
        repeat (10) @(posedge clk);
        #1 rdy_val = 1'b1;
        @(posedge clk); #1 rdy_val = 1'b0;
        wait_sig("eoi_done", 2, 1'b0, 100, n);
        @(posedge clk); #1;
        check("reack_inta", bus.inta, 0);
        check("reack_busy", bus.busy, 1);
        bus.intr = 1'b0;
        rdy_auto = 1'b1;
        wait_sig("ack2_done", 2, 1'b0, 200, n);
        repeat (5) @(posedge clk);

        // One-cycle INT pulse -> spurious IR7; START during ACK2 ignored
        @(posedge clk); #1 bus.intr = 1'b1;
        @(posedge clk); #1 bus.intr = 1'b0;
        wait_sig("sp_a1", 1, 1'b0, 20, n);
        wait_sig("sp_a1h", 1, 1'b1, 20, n);
        wait_sig("sp_a2", 1, 1'b0, 20, n);
        bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_sig("sp_done", 2, 1'b0, 200, n);
        check("start_ignored", bus.init_done, 1);
        repeat (5) @(posedge clk);

        // Reset during the ICW2 strobe, then a clean restart from ICW1
        @(posedge clk); #1 bus.start = 1'b1;
        push_init();
        @(posedge clk); #1 bus.start = 1'b0;
        n = 0;
        while (!(bus.wr == 1'b0 && bus.a0 == 1'b1) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!(bus.wr == 1'b0 && bus.a0 == 1'b1)) fail_now("icw2_timeout");
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs", bus.cs, 1);     check("arst_wr", bus.wr, 1);
        check("arst_inta", bus.inta, 1); check("arst_oe", bus.d_oe, 0);
        check("arst_done", bus.init_done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_init();

        // START and int_s together in READY: re-init first, then acknowledge
        @(posedge clk); #1 bus.intr = 1'b1;
        @(posedge clk);
        f0 = inta_falls;
        do_init();
        check("init_before_ack", inta_falls, f0);
        wait_sig("gi_ack", 1, 1'b0, 20, n);
        bus.intr = 1'b0;
        wait_sig("gi_done", 2, 1'b0, 200, n);
        repeat (5) @(posedge clk);

        // Random short INT pulses; each one yields exactly one delivered vector
        d0 = delivered;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            @(posedge clk); #1 bus.intr = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1 bus.intr = 1'b0;
            pulses++;
            repeat (5) @(posedge clk);
            #1;
            wait_sig("rnd_done", 2, 1'b0, 300, n);
            repeat (3) @(posedge clk);
        end
        #1;
        check("rnd_count", delivered - d0, pulses);
        check("wq_empty", wq.size(), 0);
        check("vq_empty", vq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pic_bus_sequencer.md
Name: pic_bus_sequencer

Overview:
- Synchronous host-side controller that drives the 8259A PIC bus pins (CS, WR, RD, A0, D, INTA) from a clocked system.
- Runs the ICW1 -> ICW2 -> ICW4 -> OCW1 initialisation, then services each INT with the two-pulse INTA sequence.
- Captures the vector byte, hands it to the CPU side over a valid/ready handshake, then issues a non-specific EOI (OCW2).
- Sits between the system core and the PIC, in place of hand-driven bus strobes.

Parameters:
ICW1_VAL, 8'h13, ICW1 byte (edge-triggered, single, ICW4 needed), written with A0=0
ICW2_VAL, 8'hA8, ICW2 vector base, A0=1
ICW4_VAL, 8'h01, ICW4 byte (8086 mode, normal EOI), A0=1
OCW1_VAL, 8'h00, OCW1 mask (all IR unmasked), A0=1
EOI_VAL, 8'h20, OCW2 non-specific EOI, A0=0
PULSE_CYC, 4, cycles a WR or INTA strobe is held low (>=1)
GAP_CYC, 4, cycles high after each strobe (>=1)

Ports:
CLK  input  1  system clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
START  input  1  one-cycle request to (re)initialise the PIC
BUSY  output  1  high whenever the state is not IDLE or READY
INIT_DONE  output  1  high after the init sequence completes; cleared by reset or re-init
CS  output  1  PIC chip select, active low
WR  output  1  PIC write strobe, active low
RD  output  1  PIC read strobe, held high (no register reads)
A0  output  1  PIC address line
D_OUT  output  8  data driven to the PIC bus
D_OE  output  1  bus-driver enable for D_OUT
D_IN  input  8  PIC data bus as seen by the host
INT  input  1  PIC interrupt output, asynchronous to CLK
VEC_VALID  output  1  captured vector available
VEC  output  8  captured vector byte
VEC_READY  input  1  CPU accepts the vector

Behaviour:
- Reset (async, any state): state=IDLE; CS=1, WR=1, RD=1, INTA=1, A0=0, D_OUT=0, D_OE=0, VEC_VALID=0, VEC=0, INIT_DONE=0, BUSY=0; sync flops and counters cleared.
- INT passes through a 2-flop synchroniser (int_s). All decisions use int_s only.
- Bus write cycle (W_SETUP -> W_STROBE -> W_GAP):
  - W_SETUP, 1 cycle: CS=0, A0 and D_OUT set, D_OE=1, WR=1.
  - W_STROBE, PULSE_CYC cycles: WR=0.
  - W_GAP, GAP_CYC cycles: WR=1, while CS, A0, D_OUT and D_OE stay stable (data hold).
  - On leaving the last write: CS=1, D_OE=0.
- Init sequence:
  - START in IDLE or READY: INIT_DONE cleared, 2-bit index set to 0.
  - Four write cycles: ICW1(A0=0), ICW2(A0=1), ICW4(A0=1), OCW1(A0=1).
  - After the final W_GAP, go to READY and set INIT_DONE the same cycle.
  - Total = 4*(1+PULSE_CYC+GAP_CYC) cycles; 36 at defaults.
- READY:
  - If START=1, restart init; START takes priority over int_s.
  - Else if int_s=1, go to ACK1.
- Acknowledge sequence:
  - ACK1: INTA=0 for PULSE_CYC, then high for GAP_CYC.
  - ACK2: INTA=0 for PULSE_CYC; D_IN sampled into VEC on the last low cycle.
  - Next cycle: INTA=1, VEC_VALID=1, state VEC_WAIT.
  - INT rising to first INTA low = 3 cycles.
  - If INT drops mid-sequence, both pulses still complete; the PIC returns its spurious IR7 vector, which is delivered normally.
- VEC_WAIT:
  - VEC and VEC_VALID held until VEC_READY=1 is sampled with VEC_VALID=1.
  - Then VEC_VALID=0 next cycle and an EOI write cycle runs (EOI_VAL, A0=0), then return to READY.
  - If int_s is still high in READY, a new ACK1 starts on the following cycle.
- Ignored inputs:
  - START outside IDLE/READY is ignored (not queued).
  - int_s in IDLE is ignored.
  - VEC_READY outside VEC_WAIT is ignored.
- Fixed outputs: RD=1 always; INTA never low while CS=0.

Test Plan:
- Reset, pulse START -> WR low pulses carry D_OUT 8'h13/A0=0, 8'hA8/A0=1, 8'h01/A0=1, 8'h00/A0=1, each 4 cycles low; INIT_DONE rises 36 cycles after START; BUSY high throughout.
- After init, raise INT, PIC model drives D_IN=8'hA8 on second INTA -> first INTA low 3 cycles after INT, two 4-cycle INTA pulses, VEC_VALID=1, VEC=8'hA8.
- Hold VEC_READY=0 for 10 cycles, then 1 -> VEC stable throughout; VEC_VALID drops next cycle; EOI write with D_OUT=8'h20, A0=0 follows; INT kept high -> second ACK1 starts 1 cycle after return to READY.
- INT pulse before START, then START -> no INTA activity until INIT_DONE=1; START asserted during ACK2 is ignored and INIT_DONE stays 1.
- Assert RST_N=0 mid-W_STROBE of ICW2 -> CS, WR, INTA go high immediately; D_OE=0, INIT_DONE=0; a subsequent START restarts from ICW1.
- START and INT both high in READY -> re-init runs first (INIT_DONE 0 -> 1), then the ack sequence starts.
